// File: rtl/seqdet_pkg.sv
// Shared definitions for the hit-count display: detector state codes,
// segment constants and the 4-bit glyph table (active-low, bit 6 = a .. bit 0 = g).
package seqdet_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } det_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Decoder codes above 9 carry the non-numeric glyphs
    localparam logic [3:0] CODE_DASH  = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        SEG_DASH,    // A
        SEG_BLANK,   // B
        SEG_BLANK,   // C
        SEG_BLANK,   // D
        SEG_BLANK,   // E
        SEG_BLANK    // F
    };

    function automatic logic [6:0] glyph(input logic [3:0] val);
        return GLYPH_TABLE[val];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment glyph; zero latency,
// no flow control.
module seg7_decode
    import seqdet_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    assign seg = glyph(val);

endmodule

// File: rtl/seq_hit_display.sv
// Counts sequence-detector hits as two BCD digits and scans them, plus the detector
// state, onto a 4-digit display; hit visible 3 edges after z rises, no backpressure.
module seq_hit_display
    import seqdet_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       z,
    input  logic [2:0] q,
    input  logic       clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       ovf
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic       z_s1, z_s2, z_s3;
    logic [2:0] q_s1, q_s2;
    logic       clr_s1, clr_s2;

    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic       ovf_q;
    logic       hit;

    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx;
    logic [3:0]        digit_val;
    logic [6:0]        seg_nxt;
    logic [3:0]        an_nxt;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            z_s1   <= 1'b0;
            z_s2   <= 1'b0;
            z_s3   <= 1'b0;
            q_s1   <= 3'd0;
            q_s2   <= 3'd0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
        end else begin
            z_s1   <= z;
            z_s2   <= z_s1;
            z_s3   <= z_s2;
            q_s1   <= q;
            q_s2   <= q_s1;
            clr_s1 <= clr;
            clr_s2 <= clr_s1;
        end
    end

    // Rising edge of the synchronized flag: one hit per z pulse regardless of width
    assign hit = z_s2 & ~z_s3;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            ovf_q  <= 1'b0;
        end else if (clr_s2) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            ovf_q  <= 1'b0;
        end else if (hit) begin
            if (ones_q == 4'd9) begin
                ones_q <= 4'd0;
                if (tens_q == 4'd9) begin
                    tens_q <= 4'd0;
                    ovf_q  <= 1'b1;
                end else begin
                    tens_q <= tens_q + 4'd1;
                end
            end else begin
                ones_q <= ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Out-of-range detector states (6, 7) display as a dash
    always_comb begin
        digit_val = CODE_BLANK;
        case (digit_idx)
            2'd0: digit_val = ones_q;
            2'd1: digit_val = tens_q;
            2'd2: digit_val = CODE_BLANK;
            2'd3: digit_val = (q_s2 > ST_F) ? CODE_DASH : {1'b0, q_s2};
            default: digit_val = CODE_BLANK;
        endcase
    end

    seg7_decode u_seg7_decode (
        .val (digit_val),
        .seg (seg_nxt)
    );

    assign an_nxt = ~(4'b0001 << digit_idx);

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_hit_display.sv
// Directed, table-driven bench for seq_hit_display with a short scan divider.
module tb_seq_hit_display;

    logic       system_clk;
    logic       reset;
    logic       z;
    logic [2:0] q;
    logic       clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    seq_hit_display #(.SCAN_DIV(4)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .z          (z),
        .q          (q),
        .clr        (clr),
        .seg        (seg),
        .an         (an),
        .ovf        (ovf)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    typedef struct {
        int         pulses;
        int         plen;
        int         clr_cycles;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
    } cnt_vec_t;

    typedef struct {
        logic [2:0] qv;
        logic [6:0] seg3;
    } disp_vec_t;

    function automatic logic [6:0] exp_glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] exp);
        int n;
        n = 0;
        while (an !== exp && n < 40) begin
            tick();
            n++;
        end
        if (an !== exp) begin
            checks++;
            errors++;
            $display("FAIL wait_an: got %b expected %b within 40 cycles", an, exp);
        end
    endtask

    task automatic pulse(input int len);
        z = 1'b1;
        repeat (len) tick();
        z = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cnt_vec_t  cv[7];
        disp_vec_t dv[6];

        cv[0] = '{8,  3, 0, 4'd0, 4'd9, 1'b0};
        cv[1] = '{1,  4, 0, 4'd1, 4'd0, 1'b0};
        cv[2] = '{89, 3, 0, 4'd9, 4'd9, 1'b0};
        cv[3] = '{1,  6, 0, 4'd0, 4'd0, 1'b1};
        cv[4] = '{5,  3, 0, 4'd0, 4'd5, 1'b1};
        cv[5] = '{0,  3, 3, 4'd0, 4'd0, 1'b0};
        cv[6] = '{12, 7, 0, 4'd1, 4'd2, 1'b0};

        dv[0] = '{3'd5, 7'b0100100};
        dv[1] = '{3'd6, 7'b1111110};
        dv[2] = '{3'd7, 7'b1111110};
        dv[3] = '{3'd0, 7'b0000001};
        dv[4] = '{3'd2, 7'b0010010};
        dv[5] = '{3'd4, 7'b1001100};

        // Reset state, then first edge after release
        reset = 1'b1;
        z     = 1'b0;
        q     = 3'd0;
        clr   = 1'b0;
        #3;
        chk("rst_an_async", an, 4'b1111);
        chk("rst_seg_async", seg, 7'b1111111);
        chk("rst_ovf_async", ovf, 1'b0);
        repeat (3) tick();
        chk("rst_an_held", an, 4'b1111);
        chk("rst_seg_held", seg, 7'b1111111);
        reset = 1'b0;
        tick();
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 7'b0000001);
        chk("first_ovf", ovf, 1'b0);

        // z held 5 cycles: count moves on the 3rd edge, exactly once
        z = 1'b1;
        tick();
        chk("lat_edge1", dut.ones_q, 4'd0);
        tick();
        chk("lat_edge2", dut.ones_q, 4'd0);
        tick();
        chk("lat_edge3", dut.ones_q, 4'd1);
        repeat (2) tick();
        z = 1'b0;
        repeat (6) tick();
        chk("single_inc_ones", dut.ones_q, 4'd1);
        chk("single_inc_tens", dut.tens_q, 4'd0);
        wait_an(4'b1110);
        chk("single_inc_seg", seg, exp_glyph(4'd1));

        // Cumulative counting table: carry, 99 wrap, sticky ovf, clear
        for (int i = 0; i < 7; i++) begin
            for (int p = 0; p < cv[i].pulses; p++) pulse(cv[i].plen);
            if (cv[i].clr_cycles > 0) begin
                clr = 1'b1;
                repeat (cv[i].clr_cycles) tick();
                clr = 1'b0;
                repeat (3) tick();
            end
            chk($sformatf("cnt%0d_tens", i), dut.tens_q, cv[i].tens);
            chk($sformatf("cnt%0d_ones", i), dut.ones_q, cv[i].ones);
            chk($sformatf("cnt%0d_ovf", i), ovf, cv[i].ovf);
            wait_an(4'b1110);
            chk($sformatf("cnt%0d_seg_ones", i), seg, exp_glyph(cv[i].ones));
            wait_an(4'b1101);
            chk($sformatf("cnt%0d_seg_tens", i), seg, exp_glyph(cv[i].tens));
        end

        // Clear to 00, then clr and a hit reach s2 on the same edge
        clr = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        repeat (3) tick();
        chk("pre_race_ones", dut.ones_q, 4'd0);
        clr = 1'b1;
        z   = 1'b1;
        repeat (3) tick();
        chk("race_ones", dut.ones_q, 4'd0);
        chk("race_tens", dut.tens_q, 4'd0);
        repeat (2) tick();
        clr = 1'b0;
        repeat (4) tick();
        z = 1'b0;
        repeat (4) tick();
        chk("race_after_ones", dut.ones_q, 4'd0);
        chk("race_after_ovf", ovf, 1'b0);

        // Digit enables step every 4 cycles, one low bit each
        wait_an(4'b0111);
        wait_an(4'b1110);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << (k / 4));
            chk($sformatf("scan_an_%0d", k), an, exp_an);
            tick();
        end

        // Detector-state digit and blank digit
        for (int i = 0; i < 6; i++) begin
            q = dv[i].qv;
            repeat (4) tick();
            wait_an(4'b0111);
            chk($sformatf("q%0d_seg", dv[i].qv), seg, dv[i].seg3);
            wait_an(4'b1011);
            chk($sformatf("blank%0d_seg", i), seg, 7'b1111111);
        end

        // Reset between edges, mid-scan and with a hit pending
        pulse(3);
        pulse(3);
        chk("pre_rst_ones", dut.ones_q, 4'd2);
        z = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_an", an, 4'b1111);
        chk("midrst_seg", seg, 7'b1111111);
        chk("midrst_ones", dut.ones_q, 4'd0);
        chk("midrst_ovf", ovf, 1'b0);
        z = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_an", an, 4'b1110);
        chk("post_rst_seg", seg, 7'b0000001);
        repeat (6) tick();
        chk("post_rst_ones", dut.ones_q, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
